// File: rtl/module_ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// instruction size and the word-alignment mask applied to redirect targets.
package module_ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    // Clears address bits [1:0]; sliced down to the datapath width by users.
    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/module_ifetch_inst_queue.sv
// Synchronous FIFO holding {pc, instr} pairs for the fetch stage.
// Head entry is presented combinationally; clear wins over push and pop.
module module_inst_queue
    import module_ifetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    // Storage, pointers and occupancy; storage is zeroed on reset so the head reads 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/module_ifetch.sv
// Instruction fetch stage: issues one word request at a time over req/ack,
// queues returned words with their PCs and hands them to decode via
// valid/ready. A redirect reloads the fetch address and flushes everything.
// Optional FETCH_PERF_EN adds saturating stall/flush performance counters.
module module_ifetch
    import module_ifetch_pkg::*;
#(
    parameter int unsigned           WORD_SIZE   = 32,
    parameter int unsigned           QUEUE_DEPTH = 2,
    parameter logic [WORD_SIZE-1:0]  RESET_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_en,
    input  logic [WORD_SIZE-1:0]  redirect_addr,
    output logic                  imem_req,
    output logic [WORD_SIZE-1:0]  imem_addr,
    input  logic                  imem_ack,
    input  logic [WORD_SIZE-1:0]  imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [WORD_SIZE-1:0]  inst_out,
    output logic [WORD_SIZE-1:0]  inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_count
`endif
);

    localparam int unsigned          CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0]        DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [WORD_SIZE-1:0] STEP_C  = WORD_SIZE'(INSTR_BYTES);

    fetch_state_e           r_state, w_state_nxt;
    logic                   r_req, w_req_nxt;
    logic [WORD_SIZE-1:0]   r_addr, w_addr_nxt;
    logic [WORD_SIZE-1:0]   r_fetch_pc, w_pc_nxt;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;
    logic [2*WORD_SIZE-1:0] w_head;
    logic [WORD_SIZE-1:0]   w_target;
    logic [WORD_SIZE-1:0]   w_pc_inc;
    logic                   w_room_after_ack;

    assign w_pop    = !w_empty && inst_ready;
    assign w_target = redirect_addr & WORD_ALIGN_MASK[WORD_SIZE-1:0];
    assign w_pc_inc = r_fetch_pc + STEP_C;
    // Room for another request once this ack is pushed: count - pop + 1 < DEPTH
    assign w_room_after_ack = (w_count - CW'(w_pop)) < (DEPTH_C - CW'(1));

    module_inst_queue #(
        .WIDTH (2 * WORD_SIZE),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect_en),
        .i_data  ({r_addr, imem_rdata}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Fetch FSM state, request and fetch-address registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_ADDR;
            r_fetch_pc <= RESET_ADDR;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_fetch_pc <= w_pc_nxt;
        end
    end

    // Next-state, request issue and push decisions; redirect has top priority
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_pc_nxt    = r_fetch_pc;
        w_push      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (redirect_en) begin
                    w_pc_nxt = w_target;
                end else if (!w_full || w_pop) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_fetch_pc;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_en) begin
                    w_pc_nxt = w_target;
                    if (imem_ack) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end else if (imem_ack) begin
                    w_push   = 1'b1;
                    w_pc_nxt = w_pc_inc;
                    if (w_room_after_ack) begin
                        w_addr_nxt = w_pc_inc;
                    end else begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (redirect_en) begin
                    w_pc_nxt = w_target;
                end
                // An ack always retires the abandoned request, even alongside a new redirect
                if (imem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst_valid = !w_empty;
    assign inst_out   = w_head[WORD_SIZE-1:0];
    assign inst_pc    = w_head[2*WORD_SIZE-1:WORD_SIZE];

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Saturating counters for decode starvation cycles and redirect cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (inst_ready && w_empty && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect_en && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_count  = r_perf_flush;
`endif

endmodule

// File: tb/tb_module_ifetch.sv
// Self-checking bench for module_ifetch: a constant vector table for the
// streaming case, hand-written corner sequences, and a randomized run
// compared every cycle against a queue-based reference model.
module tb_module_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    module_ifetch #(
        .WORD_SIZE   (32),
        .QUEUE_DEPTH (2),
        .RESET_ADDR  (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    // ---------------- reference model ----------------
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy;     // a request is outstanding
    bit          m_drop;     // its response will be thrown away
    logic [31:0] m_addr;
    logic [31:0] m_pc;

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_drop = 0;
        m_addr = 32'h0;
        m_pc   = 32'h0;
    endtask

    task automatic model_update(input logic red, input logic [31:0] raddr,
                                input logic ack, input logic [31:0] rdata,
                                input logic rdy);
        bit pop;
        pop = (m_q.size() > 0) && rdy;
        if (red) begin
            m_q.delete();
            m_pc = {raddr[31:2], 2'b00};
            if (m_busy) begin
                if (ack) begin
                    m_busy = 0;
                    m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_busy) begin
                if (ack) begin
                    if (m_drop) begin
                        m_busy = 0;
                        m_drop = 0;
                    end else begin
                        m_q.push_back('{pc: m_addr, data: rdata});
                        m_pc = m_pc + 32'd4;
                        if (m_q.size() < DEPTH) m_addr = m_pc;
                        else m_busy = 0;
                    end
                end
            end else if (m_q.size() < DEPTH) begin
                m_busy = 1;
                m_addr = m_pc;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("req", {31'b0, imem_req}, {31'b0, m_busy});
        if (m_busy) check("addr", imem_addr, m_addr);
        check("valid", {31'b0, inst_valid}, {31'b0, (m_q.size() > 0)});
        if (m_q.size() > 0) begin
            check("inst_pc", inst_pc, m_q[0].pc);
            check("inst_out", inst_out, m_q[0].data);
        end
    endtask

    // Apply inputs, clock once, advance the model, compare 1 time unit after the edge
    task automatic step(input logic red, input logic [31:0] raddr, input logic ack,
                        input logic [31:0] rdata, input logic rdy);
        redirect_en   = red;
        redirect_addr = raddr;
        imem_ack      = ack;
        imem_rdata    = rdata;
        inst_ready    = rdy;
        @(posedge clk);
        model_update(red, raddr, ack, rdata, rdy);
        #1;
        compare_model();
    endtask

    // Asynchronous reset with an ack pulsed across an edge while reset is high
    task automatic do_reset();
        reset = 1'b1;
        redirect_en = 1'b0; redirect_addr = '0; imem_ack = 1'b0;
        imem_rdata = 32'hBAD0_BAD0; inst_ready = 1'b0;
        #1;
        check("rst_req",   {31'b0, imem_req},   32'h0);
        check("rst_addr",  imem_addr,           32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_out",   inst_out,            32'h0);
        check("rst_pc",    inst_pc,             32'h0);
        imem_ack = 1'b1;
        @(posedge clk);
        #2;
        imem_ack = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_out;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 32'h1111_0000, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0, 32'h1111_0000};
        tbl[2] = '{1'b1, 32'h2222_0004, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4, 32'h2222_0004};
        tbl[3] = '{1'b1, 32'h3333_0008, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h8, 32'h3333_0008};
        tbl[4] = '{1'b1, 32'h4444_000C, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'h4444_000C};

        // Streaming with immediate ack and decode always ready
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, tbl[i].ack, tbl[i].rdata, tbl[i].rdy);
            check("tbl_req",   {31'b0, imem_req},   {31'b0, tbl[i].exp_req});
            check("tbl_addr",  imem_addr,           tbl[i].exp_addr);
            check("tbl_valid", {31'b0, inst_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                check("tbl_pc",  inst_pc,  tbl[i].exp_pc);
                check("tbl_out", inst_out, tbl[i].exp_out);
            end
        end

        // Decode stalled: queue fills with pc 0,4 and fetching stops, then drains
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0,  1'b0);
        step(1'b0, 32'h0, 1'b1, 32'hA0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'hA4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            check("full_req", {31'b0, imem_req}, 32'h0);
            check("full_pc",  inst_pc, 32'h0);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("drain_pc",   inst_pc,   32'h4);
        check("drain_addr", imem_addr, 32'h8);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("drain_empty", {31'b0, inst_valid}, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'hA8, 1'b1);
        check("resume_pc", inst_pc, 32'h8);

        // Redirect during a slow request: old word discarded, refetch at target
        do_reset();
        step(1'b0, 32'h0,   1'b0, 32'h0,  1'b1);
        step(1'b0, 32'h0,   1'b1, 32'hA0, 1'b1);
        step(1'b0, 32'h0,   1'b1, 32'hA4, 1'b1);
        step(1'b1, 32'h103, 1'b0, 32'h0,  1'b1);
        check("drop_valid", {31'b0, inst_valid}, 32'h0);
        check("drop_addr",  imem_addr, 32'h8);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check("drop_discard", {31'b0, inst_valid}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("redir_addr", imem_addr, 32'h100);
        step(1'b0, 32'h0, 1'b1, 32'hB100, 1'b1);
        check("redir_pc",  inst_pc,  32'h100);
        check("redir_out", inst_out, 32'hB100);

        // Redirect coincident with the ack that would fill the queue
        do_reset();
        step(1'b0, 32'h0,   1'b0, 32'h0,  1'b0);
        step(1'b0, 32'h0,   1'b1, 32'hA0, 1'b0);
        step(1'b1, 32'h200, 1'b1, 32'hA4, 1'b0);
        check("coin_valid", {31'b0, inst_valid}, 32'h0);
        check("coin_req",   {31'b0, imem_req},   32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("coin_addr", imem_addr, 32'h200);
        step(1'b0, 32'h0, 1'b1, 32'hC200, 1'b1);
        check("coin_pc", inst_pc, 32'h200);

        // Address wrap from the top of the address space
        do_reset();
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b1);
        check("wrap_idle", {31'b0, imem_req}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 32'h7777_0000, 1'b1);
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_pc",    inst_pc,   32'hFFFF_FFFC);

        // Reset in the middle of an outstanding request
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("rst_restart_addr",  imem_addr, 32'h0);
        check("rst_restart_valid", {31'b0, inst_valid}, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        red;
            logic        ack;
            logic        rdy;
            logic [31:0] raddr;
            red   = ($urandom_range(0, 15) == 0);
            ack   = m_busy && ($urandom_range(0, 1) == 1);
            rdy   = ($urandom_range(0, 9) < 7);
            raddr = $urandom;
            step(red, raddr, ack, $urandom, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/module_ifetch.md
Name: module_ifetch

Overview:
Instruction fetch stage that sits between the program-counter/redirect logic and the decode stage.
- Owns the running fetch address and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small queue and presents them to decode with valid/ready.
- Accepts a redirect (branch/jump target, same semantics as a PC write-enable load) that flushes all in-flight work.

Parameters:
WORD_SIZE, 32, data/address width in bits
QUEUE_DEPTH, 2, instruction queue entries; power of two, >= 2
RESET_ADDR, 0, fetch address loaded on reset; word aligned

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
redirect_en  input  1  load redirect_addr as the new fetch address and flush
redirect_addr  input  WORD_SIZE  redirect target; bits [1:0] ignored (forced 0)
imem_req  output  1  memory request valid
imem_addr  output  WORD_SIZE  word address of request
imem_ack  input  1  memory response valid; completes the current request
imem_rdata  input  WORD_SIZE  instruction word, valid with imem_ack
inst_valid  output  1  queue head holds an instruction
inst_ready  input  1  decode accepts head this cycle
inst_out  output  WORD_SIZE  instruction at queue head
inst_pc  output  WORD_SIZE  address of inst_out

Behaviour:
- Reset (async, active-high):
  - fetch_pc = RESET_ADDR; queue empty; FSM = IDLE.
  - imem_req = 0, imem_addr = RESET_ADDR, inst_valid = 0, inst_out = 0, inst_pc = 0.
  - Reset mid-request abandons the request; any ack arriving while reset is high is ignored.
- FSM states: IDLE, WAIT, DROP. At most one request is outstanding.
- IDLE:
  - If count < QUEUE_DEPTH and no redirect: assert imem_req with imem_addr = fetch_pc, go to WAIT.
  - Request issue is registered: imem_req rises in the cycle after the decision.
- WAIT:
  - imem_req and imem_addr are held stable until imem_ack.
  - On ack: push {imem_rdata, imem_addr}; fetch_pc += 4, wrapping mod 2^WORD_SIZE.
  - After the ack: if the queue will still have room, issue the next request back-to-back (req stays high, addr updates); else go to IDLE.
- DROP:
  - Entered on redirect while WAIT and no ack that cycle.
  - req/addr are held with the old address until ack; the returned data is discarded; then go to IDLE.
- Redirect:
  - Has highest priority.
  - Same edge: queue cleared, fetch_pc <= {redirect_addr[WORD_SIZE-1:2], 2'b00}.
  - inst_valid is 0 the cycle after.
  - Redirect coincident with ack: data discarded, go to IDLE.
  - Redirect in DROP: update fetch_pc only, stay in DROP.
  - A pop in the redirect cycle is still considered accepted by decode.
- Queue:
  - Head is presented combinationally from storage; pop when inst_valid && inst_ready.
  - Simultaneous push and pop on a full queue is legal; count is unchanged.
  - Never push when full: guaranteed because a request is issued only if count, minus a pop, plus in-flight is < QUEUE_DEPTH.
- Throughput: with single-cycle ack and decode always ready, one instruction per cycle after the first.
- Latency: 2 cycles from request acceptance to inst_valid.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds output perf_stall_cycles [31:0], counting cycles with inst_ready=1 and inst_valid=0.
  - Adds output perf_flush_count [31:0], counting redirect_en cycles.
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: ports and logic are absent; no other behaviour changes.

Decomposition:
- Shared package:
  - fetch FSM state enum (IDLE, WAIT, DROP).
  - INSTR_BYTES = 4 constant.
  - Word-alignment mask constant.
- Sub-module module_inst_queue:
  - Parameterised synchronous FIFO of {pc, instr}, with push, pop, clear, full, empty, count.
  - Clear wins over push.

Test Plan:
- Reset, RESET_ADDR=0, ack every cycle, inst_ready=1 → imem_addr sequence 0,4,8,C; inst_pc 0,4,8 on consecutive cycles; inst_valid from cycle 2.
- inst_ready=0, ack immediate → exactly 2 entries (pc 0,4) held; imem_req stays 0; releasing ready drains 0,4, then fetch resumes at 8.
- Redirect to 0x103 while WAIT on 0x8 with ack delayed 3 cycles → state DROP; old word discarded; next request addr 0x100; first inst_pc 0x100.
- Redirect coincident with ack and a full queue → queue empty next cycle; nothing pushed; next request to the target.
- fetch_pc = 0xFFFFFFFC with ack → next imem_addr 0x00000000 (wrap).
- Reset asserted mid-WAIT with ack pulsed during reset → outputs return to reset values immediately; no push; fetch restarts at RESET_ADDR.
